// File: rtl/systolic_skewer.sv
// systolic_skewer: per-row delay lines that stagger (skew) or realign (deskew)
// N parallel data rows around a systolic array edge. Each row carries a valid
// bit alongside its data. First/last markers travel with rows 0 and N-1. A
// self-timed drain FSM pushes the pipeline empty without help from the producer.
module systolic_skewer #(
    parameter int N          = 4,
    parameter int DATA_WIDTH = 8,
    parameter int DESKEW     = 0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [DATA_WIDTH-1:0]   data_in [N-1:0],
    input  logic                    first_in,
    input  logic                    last_in,
    input  logic                    flush,
    output logic [DATA_WIDTH-1:0]   data_out [N-1:0],
    output logic [N-1:0]            out_valid,
    output logic                    first_out,
    output logic                    last_out,
    output logic                    busy,
    output logic                    drain_done,
    output logic [N*DATA_WIDTH-1:0] data_out_flat
);

    localparam int CNT_W   = $clog2(N + 1);
    localparam int D_FIRST = (DESKEW != 0) ? N : 1;
    localparam int D_LAST  = (DESKEW != 0) ? 1 : N;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DRAIN  = 2'd2
    } state_t;

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic             drain_done_reg, drain_done_next;
    logic             advance;
    logic             accept;

    // While draining, the pipeline advances on its own and input is refused.
    assign in_ready   = (state_reg != DRAIN);
    assign busy       = (state_reg != IDLE);
    assign advance    = (state_reg == DRAIN) || en;
    assign accept     = advance && in_valid && in_ready;
    assign drain_done = drain_done_reg;

    // FSM state, drain counter and the registered drain_done pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= IDLE;
            cnt_reg        <= '0;
            drain_done_reg <= 1'b0;
        end else begin
            state_reg      <= state_next;
            cnt_reg        <= cnt_next;
            drain_done_reg <= drain_done_next;
        end
    end

    // Next-state: enter DRAIN on last accepted beat or flush, leave after N forced advances
    always_comb begin
        state_next      = state_reg;
        cnt_next        = cnt_reg;
        drain_done_next = 1'b0;
        case (state_reg)
            IDLE, STREAM: begin
                if (flush || (accept && last_in)) begin
                    state_next = DRAIN;
                    cnt_next   = '0;
                end else if (accept) begin
                    state_next = STREAM;
                end
            end
            DRAIN: begin
                // flush is deliberately ignored here so the count never restarts
                if (cnt_reg == CNT_LAST) begin
                    state_next      = IDLE;
                    cnt_next        = '0;
                    drain_done_next = 1'b1;
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    // Per-row delay chains: row gi is DEPTH stages of data plus valid
    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_row
            localparam int DEPTH = (DESKEW != 0) ? (N - gi) : (gi + 1);

            logic [DATA_WIDTH-1:0] data_reg [DEPTH];
            logic [DEPTH-1:0]      valid_reg;

            // Shift on advance; a non-accepting advance inserts a zero bubble
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int j = 0; j < DEPTH; j++) begin
                        data_reg[j] <= '0;
                    end
                    valid_reg <= '0;
                end else if (advance) begin
                    data_reg[0]  <= accept ? data_in[gi] : '0;
                    valid_reg[0] <= accept;
                    for (int j = 1; j < DEPTH; j++) begin
                        data_reg[j]  <= data_reg[j-1];
                        valid_reg[j] <= valid_reg[j-1];
                    end
                end
            end

            assign data_out[gi]                                = data_reg[DEPTH-1];
            assign out_valid[gi]                               = valid_reg[DEPTH-1];
            assign data_out_flat[gi*DATA_WIDTH +: DATA_WIDTH]  = data_reg[DEPTH-1];
        end
    endgenerate

    logic [D_FIRST-1:0] first_reg;
    logic [D_LAST-1:0]  last_reg;

    // Marker chains track row 0 (first) and row N-1 (last) so markers line up with their data
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            first_reg <= '0;
            last_reg  <= '0;
        end else if (advance) begin
            first_reg[0] <= first_in && accept;
            last_reg[0]  <= last_in && accept;
            for (int j = 1; j < D_FIRST; j++) begin
                first_reg[j] <= first_reg[j-1];
            end
            for (int j = 1; j < D_LAST; j++) begin
                last_reg[j] <= last_reg[j-1];
            end
        end
    end

    assign first_out = first_reg[D_FIRST-1];
    assign last_out  = last_reg[D_LAST-1];

endmodule

// File: tb/tb_systolic_skewer.sv
// Bench for systolic_skewer: three instances (N=4 skew, N=4 deskew, N=8/16-bit
// skew). Accepted beats push one expected entry per row with its due advance
// index; after every advancing edge each row pops its due entry (or expects a
// zero bubble), and non-advancing edges expect outputs to hold.
module tb_systolic_skewer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [2:0] rst_v, en_v, vld_v, first_v, last_v, flush_v;
    logic [15:0] din_all [3][8];

    logic [7:0]   din0 [3:0];
    logic [7:0]   din1 [3:0];
    logic [15:0]  din2 [7:0];
    logic [7:0]   dout0 [3:0];
    logic [7:0]   dout1 [3:0];
    logic [15:0]  dout2 [7:0];
    logic [3:0]   ov0, ov1;
    logic [7:0]   ov2;
    logic [31:0]  flat0, flat1;
    logic [127:0] flat2;
    logic fo0, fo1, fo2, lo0, lo1, lo2, bz0, bz1, bz2, dd0, dd1, dd2, rd0, rd1, rd2;

    logic [15:0] obs_data [3][8];
    logic [15:0] obs_flat [3][8];
    logic [7:0]  obs_valid [3];
    logic [2:0]  obs_first, obs_last, obs_busy, obs_done, obs_ready;

    systolic_skewer #(.N(4), .DATA_WIDTH(8), .DESKEW(0)) dut_skew (
        .clk(clk), .rst_n(rst_v[0]), .en(en_v[0]), .in_valid(vld_v[0]), .in_ready(rd0),
        .data_in(din0), .first_in(first_v[0]), .last_in(last_v[0]), .flush(flush_v[0]),
        .data_out(dout0), .out_valid(ov0), .first_out(fo0), .last_out(lo0),
        .busy(bz0), .drain_done(dd0), .data_out_flat(flat0)
    );

    systolic_skewer #(.N(4), .DATA_WIDTH(8), .DESKEW(1)) dut_deskew (
        .clk(clk), .rst_n(rst_v[1]), .en(en_v[1]), .in_valid(vld_v[1]), .in_ready(rd1),
        .data_in(din1), .first_in(first_v[1]), .last_in(last_v[1]), .flush(flush_v[1]),
        .data_out(dout1), .out_valid(ov1), .first_out(fo1), .last_out(lo1),
        .busy(bz1), .drain_done(dd1), .data_out_flat(flat1)
    );

    systolic_skewer #(.N(8), .DATA_WIDTH(16), .DESKEW(0)) dut_wide (
        .clk(clk), .rst_n(rst_v[2]), .en(en_v[2]), .in_valid(vld_v[2]), .in_ready(rd2),
        .data_in(din2), .first_in(first_v[2]), .last_in(last_v[2]), .flush(flush_v[2]),
        .data_out(dout2), .out_valid(ov2), .first_out(fo2), .last_out(lo2),
        .busy(bz2), .drain_done(dd2), .data_out_flat(flat2)
    );

    // Route bench-side data rows to each instance's width
    always_comb begin
        for (int r = 0; r < 4; r++) begin
            din0[r] = din_all[0][r][7:0];
            din1[r] = din_all[1][r][7:0];
        end
        for (int r = 0; r < 8; r++) begin
            din2[r] = din_all[2][r];
        end
    end

    // Gather instance outputs into uniform arrays indexed by unit
    always_comb begin
        for (int u = 0; u < 3; u++) begin
            for (int r = 0; r < 8; r++) begin
                obs_data[u][r] = '0;
                obs_flat[u][r] = '0;
            end
        end
        for (int r = 0; r < 4; r++) begin
            obs_data[0][r] = {8'h00, dout0[r]};
            obs_data[1][r] = {8'h00, dout1[r]};
            obs_flat[0][r] = {8'h00, flat0[r*8 +: 8]};
            obs_flat[1][r] = {8'h00, flat1[r*8 +: 8]};
        end
        for (int r = 0; r < 8; r++) begin
            obs_data[2][r] = dout2[r];
            obs_flat[2][r] = flat2[r*16 +: 16];
        end
        obs_valid[0] = {4'h0, ov0};
        obs_valid[1] = {4'h0, ov1};
        obs_valid[2] = ov2;
        obs_first    = {fo2, fo1, fo0};
        obs_last     = {lo2, lo1, lo0};
        obs_busy     = {bz2, bz1, bz0};
        obs_done     = {dd2, dd1, dd0};
        obs_ready    = {rd2, rd1, rd0};
    end

    typedef struct {
        int          u;
        int          r;
        logic [15:0] data;
        int          due;
        bit          first;
        bit          last;
    } ent_t;

    ent_t sb [$];

    int total = 0;
    int bad   = 0;

    // Expected model state: 0 idle, 1 stream, 2 drain
    int          st [3];
    int          dcnt [3];
    int          advc [3];
    logic [15:0] exp_d [3][8];
    bit          exp_v [3][8];
    bit          exp_f [3];
    bit          exp_l [3];
    bit          exp_done [3];

    function automatic int nrows(input int u);
        return (u == 2) ? 8 : 4;
    endfunction

    function automatic int depth(input int u, input int r);
        return (u == 1) ? (nrows(u) - r) : (r + 1);
    endfunction

    function automatic logic [15:0] mask(input int u);
        return (u == 2) ? 16'hFFFF : 16'h00FF;
    endfunction

    function automatic int find_ent(input int u, input int r);
        for (int i = 0; i < sb.size(); i++) begin
            if (sb[i].u == u && sb[i].r == r) return i;
        end
        return -1;
    endfunction

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] want);
        total++;
        assert (got === want) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, want);
        end
    endtask

    task automatic check_unit(input int u);
        int n;
        n = nrows(u);
        for (int r = 0; r < n; r++) begin
            chk($sformatf("u%0d.out_valid[%0d]", u, r), {15'd0, obs_valid[u][r]}, {15'd0, exp_v[u][r]});
            chk($sformatf("u%0d.data_out[%0d]", u, r), obs_data[u][r], exp_d[u][r]);
            chk($sformatf("u%0d.flat[%0d]", u, r), obs_flat[u][r], exp_d[u][r]);
        end
        chk($sformatf("u%0d.first_out", u), {15'd0, obs_first[u]}, {15'd0, exp_f[u]});
        chk($sformatf("u%0d.last_out", u), {15'd0, obs_last[u]}, {15'd0, exp_l[u]});
        chk($sformatf("u%0d.drain_done", u), {15'd0, obs_done[u]}, {15'd0, exp_done[u]});
        chk($sformatf("u%0d.busy", u), {15'd0, obs_busy[u]}, {15'd0, (st[u] != 0)});
        chk($sformatf("u%0d.in_ready", u), {15'd0, obs_ready[u]}, {15'd0, (st[u] != 2)});
    endtask

    task automatic clear_model(input int u);
        st[u]       = 0;
        dcnt[u]     = 0;
        exp_f[u]    = 0;
        exp_l[u]    = 0;
        exp_done[u] = 0;
        for (int r = 0; r < 8; r++) begin
            exp_d[u][r] = '0;
            exp_v[u][r] = 0;
        end
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].u == u) sb.delete(i);
        end
    endtask

    // One clock cycle on unit u: drive controls, update expectations, check after the edge
    task automatic step(input int u, input bit e, input bit v, input bit f, input bit l, input bit fl);
        int n;
        int idx;
        bit adv;
        bit acc;
        bit done_e;
        n = nrows(u);
        en_v[u]    = e;
        vld_v[u]   = v;
        first_v[u] = f;
        last_v[u]  = l;
        flush_v[u] = fl;
        adv    = (st[u] == 2) || e;
        acc    = adv && v && (st[u] != 2);
        done_e = 0;
        if (adv) advc[u]++;
        if (acc) begin
            for (int r = 0; r < n; r++) begin
                ent_t ent;
                ent.u     = u;
                ent.r     = r;
                ent.data  = din_all[u][r] & mask(u);
                ent.due   = advc[u] + depth(u, r) - 1;
                ent.first = f && (r == 0);
                ent.last  = l && (r == n - 1);
                sb.push_back(ent);
            end
            $display("u%0d beat adv=%0d row0=%0h first=%0b last=%0b", u, advc[u],
                     din_all[u][0] & mask(u), f, l);
        end
        if (st[u] == 2) begin
            dcnt[u]++;
            if (dcnt[u] == n) begin
                st[u]   = 0;
                dcnt[u] = 0;
                done_e  = 1;
            end
        end else if (fl || (acc && l)) begin
            st[u]   = 2;
            dcnt[u] = 0;
        end else if (acc) begin
            st[u] = 1;
        end
        @(posedge clk);
        #1;
        if (adv) begin
            exp_f[u] = 0;
            exp_l[u] = 0;
            for (int r = 0; r < n; r++) begin
                idx = find_ent(u, r);
                if (idx >= 0 && sb[idx].due == advc[u]) begin
                    exp_d[u][r] = sb[idx].data;
                    exp_v[u][r] = 1;
                    if (r == 0) exp_f[u] = sb[idx].first;
                    if (r == n - 1) exp_l[u] = sb[idx].last;
                    sb.delete(idx);
                end else begin
                    exp_d[u][r] = '0;
                    exp_v[u][r] = 0;
                end
            end
        end
        exp_done[u] = done_e;
        check_unit(u);
    endtask

    // Asynchronous reset in the middle of a cycle; outputs must clear without a clock edge
    task automatic hit_reset(input int u);
        rst_v[u] = 1'b0;
        #1;
        clear_model(u);
        check_unit(u);
        @(posedge clk);
        #1;
        check_unit(u);
        en_v[u]    = 0;
        vld_v[u]   = 0;
        first_v[u] = 0;
        last_v[u]  = 0;
        flush_v[u] = 0;
        @(negedge clk);
        rst_v[u] = 1'b1;
    endtask

    task automatic set_rows(input int u, input logic [15:0] base);
        for (int r = 0; r < nrows(u); r++) begin
            din_all[u][r] = base + 16'(r);
        end
    endtask

    initial begin
        int sent;
        bit v;
        rst_v   = 3'b000;
        en_v    = 3'b000;
        vld_v   = 3'b000;
        first_v = 3'b000;
        last_v  = 3'b000;
        flush_v = 3'b000;
        for (int u = 0; u < 3; u++) begin
            advc[u] = 0;
            for (int r = 0; r < 8; r++) din_all[u][r] = '0;
            clear_model(u);
        end
        #1;
        for (int u = 0; u < 3; u++) check_unit(u);
        @(negedge clk);
        rst_v = 3'b111;

        // Basic skew: single beat {1,2,3,4} with first and last
        set_rows(0, 16'd1);
        step(0, 1, 1, 1, 1, 0);
        repeat (4) step(0, 1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);

        // Stall: three beats with en dropped for five cycles mid-stream
        set_rows(0, 16'h11);
        step(0, 1, 1, 1, 0, 0);
        set_rows(0, 16'h21);
        step(0, 1, 1, 0, 0, 0);
        set_rows(0, 16'h5A);
        repeat (5) step(0, 0, 1, 0, 0, 0);
        set_rows(0, 16'h31);
        step(0, 1, 1, 0, 1, 0);
        repeat (4) step(0, 1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);

        // Flush with en low; in_valid during drain must be ignored
        set_rows(0, 16'h41);
        step(0, 1, 1, 1, 0, 0);
        set_rows(0, 16'h51);
        step(0, 1, 1, 0, 0, 0);
        set_rows(0, 16'h99);
        step(0, 0, 0, 0, 0, 1);
        repeat (4) step(0, 0, 1, 1, 1, 0);
        step(0, 0, 0, 0, 0, 0);

        // flush and last on the same edge, then flush again mid-drain
        set_rows(0, 16'h61);
        step(0, 1, 1, 1, 1, 1);
        step(0, 1, 0, 0, 0, 1);
        repeat (3) step(0, 1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);

        // flush from IDLE with an empty pipeline
        step(0, 0, 0, 0, 0, 1);
        repeat (4) step(0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);

        // Reset two cycles into a drain, then a fresh basic beat
        set_rows(0, 16'h71);
        step(0, 1, 1, 1, 1, 0);
        repeat (2) step(0, 1, 0, 0, 0, 0);
        hit_reset(0);
        set_rows(0, 16'd5);
        step(0, 1, 1, 1, 1, 0);
        repeat (4) step(0, 1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);

        // Deskew: row r carries 10+r on beat r; all rows realign on the fourth beat
        for (int k = 0; k < 4; k++) begin
            for (int r = 0; r < 4; r++) begin
                din_all[1][r] = (r == k) ? 16'(10 + r) : 16'(16'h40 + 16'(k * 4 + r));
            end
            step(1, 1, 1, (k == 0), (k == 3), 0);
        end
        for (int r = 0; r < 4; r++) begin
            chk($sformatf("deskew.aligned[%0d]", r), obs_data[1][r], 16'(10 + r));
        end
        chk("deskew.all_valid", {12'd0, obs_valid[1][3:0]}, 16'h000F);
        repeat (4) step(1, 1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);

        // Scaling: N=8, 16-bit, random 20-beat stream with gaps
        sent = 0;
        for (int it = 0; it < 200 && sent < 20; it++) begin
            v = ($urandom_range(0, 3) != 0);
            for (int r = 0; r < 8; r++) din_all[2][r] = 16'($urandom());
            step(2, 1, v, v && (sent == 0), v && (sent == 19), 0);
            if (v) sent++;
        end
        for (int i = 0; i < 10; i++) step(2, 1, 0, 0, 0, 0);

        chk("scoreboard_empty", 16'(sb.size()), 16'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
